// File: rtl/spi_flash_sequencer.sv
// ============================================================================
// Module  : spi_flash_sequencer
// Brief   : Turns 32-bit read/write requests into SPI NOR command frames
//           (WREN, PAGE PROGRAM, RDSR polling, READ) over a byte-serial engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_sequencer #(
  parameter int POLL_MAX = 1024,
  parameter int CS_GAP   = 2     // must be >= 1
) (
  input  logic        p_clk,
  input  logic        p_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sb_start,
  output logic [7:0]  sb_txbyte,
  input  logic        sb_done,
  input  logic [7:0]  sb_rxbyte,
  output logic        s_css,
  output logic        busy
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_wren = 3'd1;
  localparam logic [2:0] c_st_gap  = 3'd2;
  localparam logic [2:0] c_st_pp   = 3'd3;
  localparam logic [2:0] c_st_poll = 3'd4;
  localparam logic [2:0] c_st_read = 3'd5;
  localparam logic [2:0] c_st_resp = 3'd6;

  localparam int c_poll_w = $clog2(POLL_MAX + 1);
  localparam int c_gap_w  = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;

  localparam logic [7:0] c_op_wren = 8'h06;
  localparam logic [7:0] c_op_pp   = 8'h02;
  localparam logic [7:0] c_op_rdsr = 8'h05;
  localparam logic [7:0] c_op_read = 8'h03;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [2:0]          r_gap_next;
  logic [2:0]          w_gap_next;
  logic                w_resp_err;
  logic [2:0]          r_idx;
  logic                r_pend;
  logic [23:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [23:0]         r_rd_buf;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [c_poll_w-1:0] r_poll_cnt;
  logic [c_poll_w-1:0] w_poll_inc;
  logic [c_gap_w-1:0]  r_gap_cnt;

  logic       w_in_frame;
  logic [2:0] w_last_idx;
  logic       w_byte_done;
  logic       w_frame_done;
  logic       w_page_cross;
  logic       w_accept;

  assign w_in_frame   = (r_state == c_st_wren) || (r_state == c_st_pp) ||
                        (r_state == c_st_poll) || (r_state == c_st_read);
  assign w_byte_done  = r_pend && sb_done;
  assign w_frame_done = w_byte_done && (r_idx == w_last_idx);
  assign w_poll_inc   = r_poll_cnt + c_poll_w'(1);
  assign w_page_cross = req_addr[7:0] > 8'hFC;
  assign w_accept     = (r_state == c_st_idle) && req_valid;

  always_comb begin
    w_last_idx = 3'd0;
    case (r_state)
      c_st_pp:   w_last_idx = 3'd7;
      c_st_poll: w_last_idx = 3'd1;
      c_st_read: w_last_idx = 3'd7;
      default:   w_last_idx = 3'd0;
    endcase
  end

  // State register
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; w_resp_err is the error to report when entering RESP
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_next;
    w_resp_err   = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (req_valid) begin
          if (!req_write) begin
            w_state_next = c_st_read;
          end else if (w_page_cross) begin
            w_state_next = c_st_resp;
            w_resp_err   = 1'b1;
          end else begin
            w_state_next = c_st_wren;
          end
        end
      end
      c_st_wren: begin
        if (w_frame_done) begin
          w_state_next = c_st_gap;
          w_gap_next   = c_st_pp;
        end
      end
      c_st_pp: begin
        if (w_frame_done) begin
          w_state_next = c_st_gap;
          w_gap_next   = c_st_poll;
        end
      end
      c_st_poll: begin
        if (w_frame_done) begin
          if (!sb_rxbyte[0]) begin
            w_state_next = c_st_resp;
          end else if (w_poll_inc == c_poll_w'(POLL_MAX)) begin
            w_state_next = c_st_resp;
            w_resp_err   = 1'b1;
          end else begin
            w_state_next = c_st_gap;
            w_gap_next   = c_st_poll;
          end
        end
      end
      c_st_read: begin
        if (w_frame_done) begin
          w_state_next = c_st_resp;
        end
      end
      c_st_gap: begin
        if (r_gap_cnt == c_gap_w'(CS_GAP - 1)) begin
          w_state_next = r_gap_next;
        end
      end
      c_st_resp: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // Datapath: request capture, byte slot tracking, read assembly, counters
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      r_gap_next <= c_st_idle;
      r_idx      <= 3'd0;
      r_pend     <= 1'b0;
      r_addr     <= 24'd0;
      r_wdata    <= 32'd0;
      r_rd_buf   <= 24'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_gap_next <= w_gap_next;
      if (w_accept) begin
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_poll_cnt <= '0;
      end
      if (sb_start) begin
        r_pend <= 1'b1;
      end else if (w_byte_done) begin
        r_pend <= 1'b0;
      end
      if (w_byte_done) begin
        r_idx <= w_frame_done ? 3'd0 : r_idx + 3'd1;
      end
      if (w_byte_done && (r_state == c_st_read)) begin
        case (r_idx)
          3'd4:    r_rd_buf[7:0]   <= sb_rxbyte;
          3'd5:    r_rd_buf[15:8]  <= sb_rxbyte;
          3'd6:    r_rd_buf[23:16] <= sb_rxbyte;
          default: ;
        endcase
      end
      if ((r_state == c_st_poll) && w_frame_done) begin
        r_poll_cnt <= w_poll_inc;
      end
      if (r_state == c_st_gap) begin
        r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
      end else begin
        r_gap_cnt <= '0;
      end
      // Response fields update only on RESP entry and hold until the next one
      if ((w_state_next == c_st_resp) && (r_state != c_st_resp)) begin
        r_err   <= w_resp_err;
        r_rdata <= (r_state == c_st_read) ? {sb_rxbyte, r_rd_buf} : 32'd0;
      end
    end
  end

  // Outputs
  always_comb begin
    sb_start  = w_in_frame && !r_pend;
    s_css     = !w_in_frame;
    req_ready = (r_state == c_st_idle);
    busy      = (r_state != c_st_idle);
    rsp_valid = (r_state == c_st_resp);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
    sb_txbyte = 8'h00;
    case (r_state)
      c_st_wren: sb_txbyte = c_op_wren;
      c_st_pp: begin
        case (r_idx)
          3'd0:    sb_txbyte = c_op_pp;
          3'd1:    sb_txbyte = r_addr[23:16];
          3'd2:    sb_txbyte = r_addr[15:8];
          3'd3:    sb_txbyte = r_addr[7:0];
          3'd4:    sb_txbyte = r_wdata[7:0];
          3'd5:    sb_txbyte = r_wdata[15:8];
          3'd6:    sb_txbyte = r_wdata[23:16];
          default: sb_txbyte = r_wdata[31:24];
        endcase
      end
      c_st_poll: sb_txbyte = (r_idx == 3'd0) ? c_op_rdsr : 8'h00;
      c_st_read: begin
        case (r_idx)
          3'd0:    sb_txbyte = c_op_read;
          3'd1:    sb_txbyte = r_addr[23:16];
          3'd2:    sb_txbyte = r_addr[15:8];
          3'd3:    sb_txbyte = r_addr[7:0];
          default: sb_txbyte = 8'h00;
        endcase
      end
      default: sb_txbyte = 8'h00;
    endcase
  end

endmodule

`default_nettype wire
